// File: rtl/hpdmc_ddr_pkg.sv
// Shared definitions for the DDR write datapath: sequencer states and
// the DQS D0/D1 patterns driven into the DQS output cell.
package hpdmc_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3,
    ST_POST = 3'd4
  } wr_state_t;

  // {dqs_d0, dqs_d1} while framing the burst (preamble and postamble hold DQS low)
  localparam logic [1:0] DQS_PRE  = 2'b00;
  localparam logic [1:0] DQS_POST = 2'b00;
  // {dqs_d0, dqs_d1} during a data beat: one full DQS toggle per sys_clk
  localparam logic [1:0] DQS_BEAT = 2'b10;

endpackage

// File: rtl/hpdmc_ddr_wrpath_fmt.sv
// Registered write-word formatter: splits a FIFO word into the D0/D1 halves
// for DQ and DM. A load with an empty FIFO produces a fully masked zero beat
// so the DRAM ignores it; when not loading the outputs return to zero.
module hpdmc_ddr_wrpath_fmt #(
  parameter int DQ_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                valid,
  input  logic [2*DQ_W-1:0]   wdata,
  input  logic [DQ_W/4-1:0]   wmask,
  output logic [DQ_W-1:0]     dq_d0,
  output logic [DQ_W-1:0]     dq_d1,
  output logic [DQ_W/8-1:0]   dm_d0,
  output logic [DQ_W/8-1:0]   dm_d1
);

  localparam int NB = DQ_W / 8;

  logic [DQ_W-1:0] dq_d0_next, dq_d1_next;
  logic [NB-1:0]   dm_d0_next, dm_d1_next;
  logic [DQ_W-1:0] dq_d0_reg, dq_d1_reg;
  logic [NB-1:0]   dm_d0_reg, dm_d1_reg;

  // Per byte lane: upper half of the word goes out first (D0); an empty FIFO
  // substitutes zero data with the lane masked.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign dq_d0_next[gi*8 +: 8] = valid ? wdata[DQ_W + gi*8 +: 8] : 8'h00;
      assign dq_d1_next[gi*8 +: 8] = valid ? wdata[gi*8 +: 8]        : 8'h00;
      assign dm_d0_next[gi]        = valid ? wmask[NB + gi]          : 1'b1;
      assign dm_d1_next[gi]        = valid ? wmask[gi]               : 1'b1;
    end
  endgenerate

  // Capture the formatted word on a load edge, otherwise idle the pins at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_d0_reg <= '0;
      dq_d1_reg <= '0;
      dm_d0_reg <= '0;
      dm_d1_reg <= '0;
    end else if (load) begin
      dq_d0_reg <= dq_d0_next;
      dq_d1_reg <= dq_d1_next;
      dm_d0_reg <= dm_d0_next;
      dm_d1_reg <= dm_d1_next;
    end else begin
      dq_d0_reg <= '0;
      dq_d1_reg <= '0;
      dm_d0_reg <= '0;
      dm_d1_reg <= '0;
    end
  end

  assign dq_d0 = dq_d0_reg;
  assign dq_d1 = dq_d1_reg;
  assign dm_d0 = dm_d0_reg;
  assign dm_d1 = dm_d1_reg;

endmodule

// File: rtl/hpdmc_ddr_wrpath.sv
// DDR write-path sequencer: turns one write command into optional wait
// cycles, a one-cycle DQS preamble, BURST_BEATS data beats pulled from the
// write FIFO, and a one-cycle postamble. Registered pin outputs are computed
// from the next state so each phase appears on the pins in the cycle it owns.
module hpdmc_ddr_wrpath
  import hpdmc_ddr_pkg::*;
#(
  parameter int DQ_W        = 16,
  parameter int BURST_BEATS = 4,
  parameter int PRE_DELAY   = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                write,
  output logic                ready,
  input  logic [2*DQ_W-1:0]   wdata,
  input  logic [DQ_W/4-1:0]   wmask,
  input  logic                wvalid,
  output logic                wack,
  output logic [DQ_W-1:0]     dq_d0,
  output logic [DQ_W-1:0]     dq_d1,
  output logic [DQ_W/8-1:0]   dm_d0,
  output logic [DQ_W/8-1:0]   dm_d1,
  output logic                dqs_d0,
  output logic                dqs_d1,
  output logic                dq_oe,
  output logic                dqs_oe,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam logic [2:0] WAIT_LOAD   = (PRE_DELAY > 0) ? 3'(PRE_DELAY - 1) : 3'd0;
  localparam logic [3:0] LAST_BEAT   = 4'(BURST_BEATS - 1);
  localparam wr_state_t  START_STATE = (PRE_DELAY > 0) ? ST_WAIT : ST_PRE;

  wr_state_t  state_reg, state_next;
  logic [2:0] wait_reg, wait_next;
  logic [3:0] beat_reg, beat_next;

  logic       dq_oe_reg, dqs_oe_reg, underrun_reg;
  logic [1:0] dqs_reg, dqs_next;

  // A command is taken only between bursts (IDLE) or during the postamble.
  assign ready = (state_reg == ST_IDLE) || (state_reg == ST_POST);
  // Pop in the preamble and on every beat but the last: each pop feeds the
  // following beat, so the last beat needs none.
  assign wack  = (state_reg == ST_PRE) ||
                 ((state_reg == ST_DATA) && (beat_reg != LAST_BEAT));

  // Sequencer next-state and counter logic.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    beat_next  = beat_reg;
    case (state_reg)
      ST_IDLE, ST_POST: begin
        if (write) begin
          state_next = START_STATE;
          wait_next  = WAIT_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_reg == 3'd0) state_next = ST_PRE;
        else                  wait_next  = wait_reg - 3'd1;
      end
      ST_PRE: begin
        state_next = ST_DATA;
        beat_next  = 4'd0;
      end
      ST_DATA: begin
        if (beat_reg == LAST_BEAT) state_next = ST_POST;
        else                       beat_next  = beat_reg + 4'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= ST_IDLE;
      wait_reg  <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      beat_reg  <= beat_next;
    end
  end

  // DQS pattern for the phase about to be entered.
  always_comb begin
    dqs_next = '0;
    case (state_next)
      ST_PRE:  dqs_next = DQS_PRE;
      ST_DATA: dqs_next = DQS_BEAT;
      ST_POST: dqs_next = DQS_POST;
      default: dqs_next = '0;
    endcase
  end

  // Output enables and DQS, registered from the next state; reset releases the pins at once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dq_oe_reg  <= 1'b0;
      dqs_oe_reg <= 1'b0;
      dqs_reg    <= '0;
    end else begin
      dq_oe_reg  <= (state_next == ST_DATA);
      dqs_oe_reg <= (state_next == ST_PRE) || (state_next == ST_DATA) ||
                    (state_next == ST_POST);
      dqs_reg    <= dqs_next;
    end
  end

  // Sticky underrun flag; a fresh underrun wins over a simultaneous clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                underrun_reg <= 1'b0;
    else if (wack && !wvalid)   underrun_reg <= 1'b1;
    else if (underrun_clr)      underrun_reg <= 1'b0;
  end

  hpdmc_ddr_wrpath_fmt #(
    .DQ_W (DQ_W)
  ) u_fmt (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .load  (wack),
    .valid (wvalid),
    .wdata (wdata),
    .wmask (wmask),
    .dq_d0 (dq_d0),
    .dq_d1 (dq_d1),
    .dm_d0 (dm_d0),
    .dm_d1 (dm_d1)
  );

  assign dq_oe    = dq_oe_reg;
  assign dqs_oe   = dqs_oe_reg;
  assign dqs_d0   = dqs_reg[1];
  assign dqs_d1   = dqs_reg[0];
  assign underrun = underrun_reg;

endmodule
